// File: rtl/dshot_pkg.sv
// Shared types, constants and the packet builder for the DShot frame scheduler.
package dshot_pkg;

  localparam int NUM_CHAN        = 4;
  localparam int PKT_BITS        = 16;
  localparam int TELEM_THRESHOLD = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_e;

  // 11-bit throttle plus telemetry flag, followed by the 4-bit XOR checksum of the three nibbles.
  function automatic logic [15:0] dshot_packet(input logic [10:0] throttle);
    logic [11:0] data12;
    data12 = {throttle, (throttle >= 11'(TELEM_THRESHOLD))};
    return {data12, data12[11:8] ^ data12[7:4] ^ data12[3:0]};
  endfunction

endpackage

// File: rtl/dshot_bit_tx.sv
// Shared DShot serializer: shifts a 16-bit packet out MSB first, one bit
// every BIT_CYCLES clocks, with a high time that encodes the bit value.
module dshot_bit_tx
  import dshot_pkg::*;
#(
  parameter int BIT_CYCLES   = 3,
  parameter int HIGH1_CYCLES = 2,
  parameter int HIGH0_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] packet,
  input  logic        start,
  output logic        line,
  output logic        done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(PKT_BITS);

  logic [15:0]   shreg_q, shreg_d;
  logic [CW-1:0] c_q, c_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sending_q, sending_d;
  logic          last_cyc;

  // Line level, end-of-packet flag and counter/shift-register advance.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    shreg_d   = shreg_q;
    c_d       = c_q;
    bit_d     = bit_q;
    sending_d = sending_q;

    last_cyc = sending_q && (c_q == CW'(BIT_CYCLES - 1));
    done     = last_cyc && (bit_q == BW'(PKT_BITS - 1));
    line     = sending_q && (shreg_q[15] ? (c_q < CW'(HIGH1_CYCLES))
                                         : (c_q < CW'(HIGH0_CYCLES)));

    if (start) begin
      shreg_d   = packet;
      c_d       = '0;
      bit_d     = '0;
      sending_d = 1'b1;
    end else if (sending_q) begin
      if (last_cyc) begin
        c_d   = '0;
        shreg_d = {shreg_q[14:0], 1'b0};
        bit_d = bit_q + 1'b1;
        if (done) sending_d = 1'b0;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Serializer state registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset) begin
      shreg_q   <= '0;
      c_q       <= '0;
      bit_q     <= '0;
      sending_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      c_q       <= c_d;
      bit_q     <= bit_d;
      sending_q <= sending_d;
    end
  end

endmodule

// File: rtl/dshot_frame_scheduler.sv
// Four-channel DShot frame scheduler: throttle registers, per-frame snapshot,
// frame timer and sequencing FSM driving one shared serializer onto four lines.
module dshot_frame_scheduler
  import dshot_pkg::*;
#(
  parameter int BIT_CYCLES   = 3,
  parameter int HIGH1_CYCLES = 2,
  parameter int HIGH0_CYCLES = 1,
  parameter int GAP_CYCLES   = 2,
  parameter int FRAME_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [1:0]  wr_chan,
  input  logic [10:0] wr_throttle,
  output logic [3:0]  out,
  output logic        busy,
  output logic [1:0]  active_chan,
  output logic        frame_done,
  output logic        overrun
);

  localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [10:0]   thr_q  [NUM_CHAN];
  logic [10:0]   thr_d  [NUM_CHAN];
  logic [10:0]   snap_q [NUM_CHAN];
  logic [10:0]   snap_d [NUM_CHAN];
  state_e        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    out_q, out_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;
  logic          tick;
  logic          tx_line, tx_done;
  logic [15:0]   tx_packet;

  assign tx_packet = dshot_packet(snap_q[ch_q]);

  dshot_bit_tx #(
    .BIT_CYCLES  (BIT_CYCLES),
    .HIGH1_CYCLES(HIGH1_CYCLES),
    .HIGH0_CYCLES(HIGH0_CYCLES)
  ) u_bit_tx (
    .clock (clock),
    .reset (reset),
    .packet(tx_packet),
    .start (state_q == LOAD),
    .line  (tx_line),
    .done  (tx_done)
  );

  // Register writes, frame timer, channel sequencing and output steering.
  always_comb begin
    tick    = enable && (timer_q == '0);
    timer_d = (!enable || timer_q == TW'(FRAME_CYCLES - 1)) ? '0 : timer_q + 1'b1;

    for (int i = 0; i < NUM_CHAN; i++) begin
      thr_d[i]  = (wr_en && wr_chan == 2'(i)) ? wr_throttle : thr_q[i];
      snap_d[i] = snap_q[i];
    end

    state_d      = state_q;
    ch_d         = ch_q;
    gap_d        = gap_q;
    frame_done_d = 1'b0;
    overrun_d    = tick && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (tick) begin
          // Snapshot from thr_d so a write on the frame-start edge goes out this frame.
          for (int i = 0; i < NUM_CHAN; i++) snap_d[i] = thr_d[i];
          ch_d    = 2'd0;
          state_d = LOAD;
        end
      end
      LOAD: state_d = SEND;
      SEND: begin
        if (tx_done) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (ch_q == 2'd3) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = LOAD;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    out_d = '0;
    if (tx_line) out_d[ch_q] = 1'b1;
  end

  // Scheduler state, throttle/snapshot registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      out_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      // NOTE: these arrays are a handful of flops, not RAM, so clearing them on reset is cheap and required.
      for (int i = 0; i < NUM_CHAN; i++) begin
        thr_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      out_q        <= out_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < NUM_CHAN; i++) begin
        thr_q[i]  <= thr_d[i];
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign out         = out_q;
  assign busy        = (state_q != IDLE);
  assign active_chan = ch_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dshot_frame_scheduler.sv
// Self-checking bench: decodes ESC pulse widths back into packets and compares
// them, plus frame timing and overrun behaviour, against an arithmetic model.
module tb_dshot_frame_scheduler;

  logic        clock;
  logic        reset;
  logic        en1, en2, wr_en;
  logic [1:0]  wr_chan;
  logic [10:0] wr_throttle;
  logic [3:0]  out1, out2;
  logic        busy1, busy2, done1, done2, ovr1, ovr2;
  logic [1:0]  ach1, ach2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct { int ch; int pkt; } rx_t;
  rx_t rx_q[$];
  int  run[4], nbits[4], acc[4];
  int  multi_hi = 0, bad_pulse = 0, ovr1_cnt = 0, d2_cnt = 0;
  int  b1_rise[$], b1_fall[$], d1_cyc[$];
  int  b2_rise[$], b2_fall[$], ov2[$];
  logic busy1_prev = 1'b0, busy2_prev = 1'b0;
  int  m_thr[4];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dshot_frame_scheduler #(.FRAME_CYCLES(256)) dut (
    .clock(clock), .reset(reset), .enable(en1), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_throttle(wr_throttle), .out(out1), .busy(busy1), .active_chan(ach1),
    .frame_done(done1), .overrun(ovr1)
  );

  dshot_frame_scheduler #(.FRAME_CYCLES(100)) dut_ovr (
    .clock(clock), .reset(reset), .enable(en2), .wr_en(wr_en), .wr_chan(wr_chan),
    .wr_throttle(wr_throttle), .out(out2), .busy(busy2), .active_chan(ach2),
    .frame_done(done2), .overrun(ovr2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // DShot packet from the throttle value using plain arithmetic.
  function automatic int model_pkt(input int t);
    int d, cs;
    d  = t * 2 + ((t >= 48) ? 1 : 0);
    cs = ((d >> 8) ^ (d >> 4) ^ d) & 15;
    return d * 16 + cs;
  endfunction

  function automatic int pick_throttle();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 47;
      2:       return 48;
      3:       return 2047;
      default: return int'($urandom_range(0, 2047));
    endcase
  endfunction

  // One negedge sample of both DUTs: pulse-width decode and event logging.
  task automatic monitor_step();
    rx_t r;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        run[i] = 0; nbits[i] = 0; acc[i] = 0;
      end
      busy1_prev = 1'b0;
      busy2_prev = 1'b0;
      return;
    end
    if ($countones(out1) > 1) multi_hi++;
    for (int i = 0; i < 4; i++) begin
      if (out1[i]) begin
        run[i]++;
      end else if (run[i] > 0) begin
        if (run[i] > 2) bad_pulse++;
        acc[i] = (acc[i] << 1) | ((run[i] == 2) ? 1 : 0);
        nbits[i]++;
        run[i] = 0;
        if (nbits[i] == 16) begin
          r.ch = i; r.pkt = acc[i];
          rx_q.push_back(r);
          nbits[i] = 0; acc[i] = 0;
        end
      end
    end
    if (busy1 && !busy1_prev) b1_rise.push_back(cyc);
    if (!busy1 && busy1_prev) b1_fall.push_back(cyc);
    busy1_prev = busy1;
    if (done1) d1_cyc.push_back(cyc);
    if (ovr1) ovr1_cnt++;
    if (busy2 && !busy2_prev) b2_rise.push_back(cyc);
    if (!busy2 && busy2_prev) b2_fall.push_back(cyc);
    busy2_prev = busy2;
    if (done2) d2_cnt++;
    if (ovr2) ov2.push_back(cyc);
  endtask

  initial forever begin
    @(negedge clock);
    monitor_step();
  end

  task automatic wr(input int ch, input int val);
    @(negedge clock);
    wr_en = 1'b1; wr_chan = ch[1:0]; wr_throttle = val[10:0];
    m_thr[ch] = val;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
  endtask

  task automatic wait_busy_chan(input int ch);
    int k = 0;
    while (!(busy1 && ach1 == ch[1:0]) && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 2000) check("chan_timeout", ach1, ch);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy1 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    if (k >= 2000) check("idle_timeout", busy1, 0);
  endtask

  task automatic expect_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_t[4];
    rx_t r;
    exp_t[0] = e0; exp_t[1] = e1; exp_t[2] = e2; exp_t[3] = e3;
    wait_rx(4);
    for (int i = 0; i < 4; i++) begin
      if (rx_q.size() > 0) begin
        r = rx_q.pop_front();
        check({tag, "_ch"}, r.ch, i);
        check({tag, "_pkt"}, r.pkt, model_pkt(exp_t[i]));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, v, start, act, nr;
    int exp_ov[$], exp_st[$];

    reset = 1'b1; en1 = 1'b0; en2 = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_throttle = '0;
    for (int i = 0; i < 4; i++) m_thr[i] = 0;
    repeat (3) @(negedge clock);
    check("rst_out", out1, 0);
    check("rst_busy", busy1, 0);
    check("rst_chan", ach1, 0);
    check("rst_done", done1, 0);
    check("rst_ovr", ovr1, 0);
    reset = 1'b0;

    // Overrun: 100-cycle frame period against a 204-cycle frame.
    @(negedge clock);
    k = cyc; en2 = 1'b1;
    wait_until(k + 650);
    en2 = 1'b0;
    repeat (300) @(negedge clock);
    start = -100000;
    for (int t = k + 1; t <= k + 650; t += 100) begin
      if (t <= start + 204) exp_ov.push_back(t);
      else begin
        start = t;
        exp_st.push_back(t);
      end
    end
    check("ovr_count", ov2.size(), exp_ov.size());
    for (int i = 0; i < exp_ov.size() && i < ov2.size(); i++) check("ovr_cyc", ov2[i], exp_ov[i]);
    check("ovr_frames", b2_rise.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < b2_rise.size(); i++) check("ovr_start", b2_rise[i], exp_st[i]);
    for (int i = 0; i < b2_rise.size() && i < b2_fall.size(); i++)
      check("ovr_busy_len", b2_fall[i] - b2_rise[i], 204);
    check("ovr_done_cnt", d2_cnt, exp_st.size());

    // Sequencing and packet values on the 256-cycle instance.
    wr(0, 1000); wr(1, 48); wr(2, 47); wr(3, 2047);
    @(negedge clock);
    k = cyc; en1 = 1'b1;
    expect_frame("f1", 1000, 48, 47, 2047);

    // Mid-frame write only lands in the following frame.
    wait_until(k + 267);
    check("snap_ch0", ach1, 0);
    wr(2, 0);
    expect_frame("f2", 1000, 48, 47, 2047);

    // Write on the frame-start edge is sent in that frame.
    v = pick_throttle();
    wait_until(k + 512);
    wr_en = 1'b1; wr_chan = 2'd3; wr_throttle = v[10:0]; m_thr[3] = v;
    @(negedge clock);
    wr_en = 1'b0;
    expect_frame("f3", 1000, 48, 0, v);

    check("f1_start", (b1_rise.size() > 0) ? b1_rise[0] : -1, k + 1);
    check("f2_period", (b1_rise.size() > 1) ? b1_rise[1] - b1_rise[0] : -1, 256);
    check("f3_period", (b1_rise.size() > 2) ? b1_rise[2] - b1_rise[1] : -1, 256);
    check("f1_busy_len", (b1_fall.size() > 0) ? b1_fall[0] - b1_rise[0] : -1, 204);
    check("f2_busy_len", (b1_fall.size() > 1) ? b1_fall[1] - b1_rise[1] : -1, 204);
    check("f1_done_at_fall", (d1_cyc.size() > 0) ? d1_cyc[0] : -1, (b1_fall.size() > 0) ? b1_fall[0] : -2);
    check("f2_done_at_fall", (d1_cyc.size() > 1) ? d1_cyc[1] : -1, (b1_fall.size() > 1) ? b1_fall[1] : -2);

    // Randomized throttle frames.
    for (int f = 0; f < 3; f++) begin
      wait_idle();
      for (int c = 0; c < 4; c++) wr(c, pick_throttle());
      expect_frame("rand", m_thr[0], m_thr[1], m_thr[2], m_thr[3]);
    end

    // Enable drop during channel 1: frame completes, then silence.
    wait_busy_chan(1);
    en1 = 1'b0;
    expect_frame("drop", m_thr[0], m_thr[1], m_thr[2], m_thr[3]);
    wait_idle();
    nr = b1_rise.size();
    act = 0;
    repeat (600) begin
      @(negedge clock);
      if (out1 != 4'd0 || busy1) act++;
    end
    check("drop_quiet", act, 0);
    check("drop_no_frame", b1_rise.size(), nr);

    // Asynchronous reset mid-bit on channel 2.
    en1 = 1'b1;
    wait_busy_chan(2);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_out", out1, 0);
    check("rst_mid_busy", busy1, 0);
    check("rst_mid_chan", ach1, 0);
    check("rst_mid_rx", rx_q.size(), 2);
    rx_q.delete();
    for (int i = 0; i < 4; i++) m_thr[i] = 0;
    en1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    act = 0;
    repeat (30) begin
      @(negedge clock);
      if (out1 != 4'd0 || busy1) act++;
    end
    check("post_rst_quiet", act, 0);
    en1 = 1'b1;
    expect_frame("post_rst", 0, 0, 0, 0);
    en1 = 1'b0;
    wait_idle();

    check("one_line_high", multi_hi, 0);
    check("pulse_width", bad_pulse, 0);
    check("no_overrun_256", ovr1_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
